// File: rtl/sd_block_writer_pkg.sv
// Shared constants, error codes and FSM encoding for the SPI-mode SD block writer.
package sd_block_writer_pkg;

  localparam logic [7:0] Cmd24Byte  = 8'h58;
  localparam logic [7:0] StartToken = 8'hFE;
  localparam logic [7:0] FillByte   = 8'hFF;
  localparam logic [4:0] DrespOk    = 5'h05;

  localparam logic [2:0] ErrNone        = 3'd0;
  localparam logic [2:0] ErrR1Timeout   = 3'd1;
  localparam logic [2:0] ErrR1Bad       = 3'd2;
  localparam logic [2:0] ErrRejected    = 3'd3;
  localparam logic [2:0] ErrBusyTimeout = 3'd4;

  typedef enum logic [3:0] {
    StIdle, StCmd, StR1, StGap, StToken, StData, StCrc, StDresp, StBusy, StFin, StErr
  } wr_state_e;

  // Frame is FF, 58, addr[31:24..7:0], FF (dummy CRC) for idx 0..6.
  function automatic logic [7:0] cmd_byte(input logic [2:0] idx, input logic [31:0] addr);
    logic [7:0] b;
    case (idx)
      3'd1:    b = Cmd24Byte;
      3'd2:    b = addr[31:24];
      3'd3:    b = addr[23:16];
      3'd4:    b = addr[15:8];
      3'd5:    b = addr[7:0];
      default: b = FillByte;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sd_block_writer_xfer.sv
// SPI mode-0 byte engine: shifts one byte out on mosi and in from miso, MSB first.
module spi_byte_xfer #(
  parameter int unsigned SCK_HALF = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic       miso,
  output logic [7:0] rx,
  output logic       done,
  output logic       busy,
  output logic       sclk,
  output logic       mosi
);

  logic        active_q;
  logic [15:0] div_q;
  logic [2:0]  bit_q;
  logic [7:0]  sh_q;
  logic [7:0]  rx_q;
  logic        sclk_q;
  logic        done_q;
  logic        half_end;

  assign half_end = (div_q == 16'(SCK_HALF - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      sh_q     <= 8'hFF;
      rx_q     <= '0;
      sclk_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!active_q) begin
        if (start) begin
          active_q <= 1'b1;
          sh_q     <= tx;
          div_q    <= '0;
          bit_q    <= '0;
          sclk_q   <= 1'b0;
        end
      end else if (!half_end) begin
        div_q <= div_q + 16'd1;
      end else begin
        div_q <= '0;
        if (!sclk_q) begin
          sclk_q <= 1'b1;
          rx_q   <= {rx_q[6:0], miso};
        end else begin
          // Ones shift in behind the data so mosi settles high after the last bit.
          sclk_q <= 1'b0;
          sh_q   <= {sh_q[6:0], 1'b1};
          bit_q  <= bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            active_q <= 1'b0;
            done_q   <= 1'b1;
          end
        end
      end
    end
  end

  assign rx   = rx_q;
  assign done = done_q;
  assign busy = active_q;
  assign sclk = sclk_q;
  assign mosi = sh_q[7];

endmodule

// File: rtl/sd_block_writer.sv
// CMD24 single-block write engine: command, R1, token, 512 data bytes, response, busy wait.
module sd_block_writer
  import sd_block_writer_pkg::*;
#(
  parameter int unsigned SCK_HALF     = 4,
  parameter int unsigned R1_TRIES     = 8,
  parameter int unsigned BUSY_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_req,
  input  logic [31:0] block_addr,
  output logic        wr_busy,
  output logic        wr_done,
  output logic        wr_err,
  output logic [2:0]  err_code,
  output logic [8:0]  buf_addr,
  input  logic [7:0]  buf_data,
  output logic        cs,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso
);

  wr_state_e   state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [15:0] poll_q, poll_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  tx_q, tx_d;
  logic        start_q, start_d;
  logic [8:0]  buf_addr_q, buf_addr_d;
  logic [2:0]  err_code_q, err_code_d;
  logic [7:0]  pref_q;
  logic [7:0]  xfer_rx;
  logic        xfer_done;
  logic        xfer_busy;
  logic        poll_last_r1;
  logic        poll_last_busy;

  spi_byte_xfer #(
    .SCK_HALF(SCK_HALF)
  ) u_xfer (
    .clk  (clk),
    .rst  (rst),
    .start(start_q),
    .tx   (tx_q),
    .miso (miso),
    .rx   (xfer_rx),
    .done (xfer_done),
    .busy (xfer_busy),
    .sclk (sclk),
    .mosi (mosi)
  );

  assign poll_last_r1   = (32'(poll_q) + 32'd1) >= R1_TRIES;
  assign poll_last_busy = (32'(poll_q) + 32'd1) >= BUSY_TIMEOUT;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    poll_d     = poll_q;
    addr_d     = addr_q;
    tx_d       = tx_q;
    start_d    = 1'b0;
    buf_addr_d = buf_addr_q;
    err_code_d = err_code_q;
    wr_done    = 1'b0;
    wr_err     = 1'b0;
    if (state_q == StIdle) begin
      if (wr_req) begin
        state_d    = StCmd;
        addr_d     = block_addr;
        err_code_d = ErrNone;
        cnt_d      = '0;
        buf_addr_d = '0;
        tx_d       = FillByte;
        start_d    = 1'b1;
      end
    end else if (xfer_done) begin
      // Every state except FIN/ERR launches another byte, 0xFF unless overridden.
      start_d = 1'b1;
      tx_d    = FillByte;
      cnt_d   = cnt_q + 10'd1;
      unique case (state_q)
        StCmd: begin
          if (cnt_q == 10'd6) begin
            state_d = StR1;
            poll_d  = '0;
          end else begin
            tx_d = cmd_byte(cnt_q[2:0] + 3'd1, addr_q);
          end
        end
        StR1: begin
          if (!xfer_rx[7]) begin
            if (xfer_rx == 8'h00) begin
              state_d = StGap;
            end else begin
              state_d    = StErr;
              err_code_d = ErrR1Bad;
            end
          end else if (poll_last_r1) begin
            state_d    = StErr;
            err_code_d = ErrR1Timeout;
          end else begin
            poll_d = poll_q + 16'd1;
          end
        end
        StGap: begin
          state_d = StToken;
          tx_d    = StartToken;
        end
        StToken: begin
          state_d    = StData;
          cnt_d      = '0;
          tx_d       = pref_q;
          buf_addr_d = 9'd1;
        end
        StData: begin
          if (cnt_q == 10'd511) begin
            state_d = StCrc;
            cnt_d   = '0;
          end else begin
            tx_d       = pref_q;
            buf_addr_d = buf_addr_q + 9'd1;
          end
        end
        StCrc: begin
          if (cnt_q == 10'd1) state_d = StDresp;
        end
        StDresp: begin
          if (xfer_rx[4:0] == DrespOk) begin
            state_d = StBusy;
            poll_d  = '0;
          end else begin
            state_d    = StErr;
            err_code_d = ErrRejected;
          end
        end
        StBusy: begin
          if (xfer_rx == 8'hFF) begin
            state_d = StFin;
          end else if (poll_last_busy) begin
            state_d    = StErr;
            err_code_d = ErrBusyTimeout;
          end else begin
            poll_d = poll_q + 16'd1;
          end
        end
        StFin: begin
          start_d = 1'b0;
          wr_done = 1'b1;
          state_d = StIdle;
        end
        StErr: begin
          start_d = 1'b0;
          wr_err  = 1'b1;
          state_d = StIdle;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      poll_q     <= '0;
      addr_q     <= '0;
      tx_q       <= FillByte;
      start_q    <= 1'b0;
      buf_addr_q <= '0;
      err_code_q <= ErrNone;
      pref_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      poll_q     <= poll_d;
      addr_q     <= addr_d;
      tx_q       <= tx_d;
      start_q    <= start_d;
      buf_addr_q <= buf_addr_d;
      err_code_q <= err_code_d;
      // SRAM data for the next byte settles long before the current byte ends.
      if (xfer_busy) pref_q <= buf_data;
    end
  end

  assign wr_busy  = (state_q != StIdle);
  assign cs       = (state_q == StIdle) || (state_q == StFin) || (state_q == StErr);
  assign err_code = err_code_q;
  assign buf_addr = buf_addr_q;

endmodule
